soc_system_speed_ramp_pio: RTL
==============================

Name: soc_system_speed_ramp_pio

Overview:
- Multi-channel Avalon-MM slave output register for motor speed setpoints. Successor to the single 32-bit speed output PIO.
- HPS writes a target per channel. Each channel's driven value slews toward its target by a programmable step once per prescaled tick, limiting motor current surges.
- Sits on the lightweight HPS-to-FPGA bridge. `out_port` feeds the motor PWM/driver logic.

Parameters:
- NUM_CH, 2, number of speed channels (1..4).
- DATA_W, 16, channel width in bits (2..32); values are signed two's complement.
- PRESC_W, 16, width of the tick prescaler register/counter.
- STEP_RST, 1, reset value of STEP (unsigned, DATA_W-1 bits used).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  4  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address
- out_port  out  NUM_CH*DATA_W  current values, channel i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Interface is fixed: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- A write occurs when chipselect=1 and write_n=0 on a clk edge. Writes take zero wait states and are registered on that edge. Writes to read-only or unmapped addresses are ignored.
- Address map:
  - 0 CTRL (RW): bit0 EN, bit1 SNAP (write-1 pulse, reads 0).
  - 1 STATUS (RO): bit i = AT[i] (cur[i]==tgt[i]); bit31 = AND of all AT.
  - 2 STEP (RW): unsigned, width DATA_W-1.
  - 3 PRESC (RW): width PRESC_W.
  - 4+i TGT[i] (RW).
  - 8+i CUR[i] (RO).
  - Addresses for channels i>=NUM_CH are unmapped and read 0.
- Read data:
  - TGT and CUR reads are sign-extended to 32 bits.
  - Other registers are zero-extended.
  - Unmapped addresses read 0.
- Target writes: TGT[i] takes writedata[DATA_W-1:0]; upper bits are ignored.
- Reset values: all TGT=0, CUR=0, out_port=0, EN=0, STEP=STEP_RST, PRESC=0, prescale counter=0, readdata follows address with reset contents.
- Prescaler:
  - The counter increments every clk while EN=1.
  - When counter==PRESC: tick=1 that cycle and the counter returns to 0.
  - PRESC=0 gives a tick every cycle.
  - EN=0 holds the counter at 0 and gives no ticks.
  - Writing PRESC clears the counter.
- Ramp on tick, per channel, signed compare, arithmetic done in DATA_W+1 bits so there is no overflow:
  - cur<tgt: cur=min(cur+STEP, tgt).
  - cur>tgt: cur=max(cur-STEP, tgt).
  - Equal: hold.
  - STEP=0 gives bypass: on every tick cur=tgt.
- Latency:
  - CUR changes on the tick edge.
  - out_port is the registered CUR, with no extra stage.
  - STATUS is combinational from the registers.
- EN=0 freezes CUR; targets stay writable.
- SNAP:
  - Writing CTRL with bit1=1 loads cur[i]=tgt[i] for all channels on that edge, regardless of EN.
  - The EN bit of the same write takes effect on the same edge.
- Simultaneous events:
  - SNAP together with a tick: SNAP wins.
  - TGT[i] write together with a tick: the tick uses the old target; the new target applies from the next tick.
  - STEP write together with a tick: the tick uses the old STEP.
- Wrap-around: impossible by construction. Steps clamp at the target, and the target is always a representable value.
- Reset mid-ramp: all state returns asynchronously to reset values. out_port goes to 0 immediately on reset assertion.

Test Plan:
- Reset → write TGT0=100, STEP=10, PRESC=0, CTRL=1 → CUR0 = 10, 20, …, 100 on successive cycles; STATUS bit0 and bit31 rise on the cycle CUR0 reaches 100; out_port[15:0]=100.
- PRESC=3, STEP=7, TGT1=-20 from 0 → CUR1 steps every 4th cycle: -7, -14, -20 (clamped); readdata@9 = 0xFFFFFFEC.
- TGT0=50 with CTRL=0, then write CTRL=2 → CUR0=50 on the write edge; EN stays 0; no further change when TGT0 is later rewritten to 0.
- STEP=0, EN=1, PRESC=0 → CUR follows TGT one cycle after each TGT write; writing TGT0 on the same edge as a tick keeps the old value that cycle.
- Boundary: DATA_W=16, CUR0=32760, TGT0=32767, STEP=100 → CUR0=32767, no wrap; then TGT0=-32768 → ramps down by 100 and clamps at -32768.
- Assert reset_n low mid-ramp → out_port, CUR and TGT read 0; STEP reads STEP_RST; readdata@address 15 = 0 throughout.

Source files
------------

// File: rtl/soc_system_speed_ramp_pio.sv
// rtl/soc_system_speed_ramp_pio.sv - multi-channel slewing speed setpoint PIO
// Each channel slews its output toward an HPS-written target by STEP per prescaled tick.
module soc_system_speed_ramp_pio #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 16,
  parameter int PRESC_W  = 16,
  parameter int STEP_RST = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [3:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH*DATA_W-1:0] out_port
);

  localparam int STEP_W = DATA_W - 1;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_STATUS = 4'd1;
  localparam logic [3:0] A_STEP   = 4'd2;
  localparam logic [3:0] A_PRESC  = 4'd3;

  logic               en;
  logic [STEP_W-1:0]  step;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] cnt;
  logic [DATA_W-1:0]  tgt [NUM_CH];
  logic [DATA_W-1:0]  cur [NUM_CH];
  logic [NUM_CH-1:0]  at;

  logic wr_en;
  logic tick;
  logic snap;

  assign wr_en = chipselect & ~write_n;
  assign tick  = en && (cnt == presc);
  assign snap  = wr_en && (address == A_CTRL) && writedata[1];

  // Widened by one bit so cur +/- step can never wrap before the clamp.
  function automatic logic [DATA_W-1:0] ramp_next(input logic [DATA_W-1:0] c,
                                                  input logic [DATA_W-1:0] t,
                                                  input logic [STEP_W-1:0] s);
    logic signed [DATA_W:0] ce;
    logic signed [DATA_W:0] te;
    logic signed [DATA_W:0] se;
    logic signed [DATA_W:0] up;
    logic signed [DATA_W:0] dn;
    ce = {c[DATA_W-1], c};
    te = {t[DATA_W-1], t};
    se = {2'b00, s};
    up = ce + se;
    dn = ce - se;
    if (s == '0)
      return t;
    else if (ce < te)
      return (up > te) ? t : up[DATA_W-1:0];
    else if (ce > te)
      return (dn < te) ? t : dn[DATA_W-1:0];
    else
      return c;
  endfunction

  function automatic logic [31:0] sext32(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = v;
    return 32'(s);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en    <= 1'b0;
      step  <= STEP_W'(STEP_RST);
      presc <= '0;
      cnt   <= '0;
    end else begin
      if (wr_en && address == A_CTRL)
        en <= writedata[0];
      if (wr_en && address == A_STEP)
        step <= writedata[STEP_W-1:0];
      if (wr_en && address == A_PRESC) begin
        presc <= PRESC_W'(writedata);
        cnt   <= '0;
      end else if (!en || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The tick reads tgt/step before this edge's write lands, so new values apply next tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= '0;
        cur[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && address == 4'(4 + i))
          tgt[i] <= writedata[DATA_W-1:0];
        if (snap)
          cur[i] <= tgt[i];
        else if (tick)
          cur[i] <= ramp_next(cur[i], tgt[i], step);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      at[i] = (cur[i] == tgt[i]);
      out_port[i*DATA_W +: DATA_W] = cur[i];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL:   readdata = {31'b0, en};
      A_STATUS: readdata = 32'(at) | {&at, 31'b0};
      A_STEP:   readdata = 32'(step);
      A_PRESC:  readdata = 32'(presc);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == 4'(4 + i))
            readdata = sext32(tgt[i]);
          if (address == 4'(8 + i))
            readdata = sext32(cur[i]);
        end
      end
    endcase
  end

endmodule
